// File: rtl/mux_scan_pkg.sv
// Shared types for the registered N-to-1 channel scanner.
// Optional MUXSCAN_MASK_EN adds the enabled-channel search helper.
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

`ifdef MUXSCAN_MASK_EN
  localparam int MAX_CH = 256;

  // Lowest enabled channel strictly above cur, or -1 if none.
  // cur = -1 yields the first enabled channel.
  function automatic int next_en(
    input logic [MAX_CH-1:0] mask,
    input int                cur,
    input int                n_ch
  );
    next_en = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k > cur && k < n_ch && mask[k]) next_en = k;
    end
  endfunction
`endif

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational WIDTH-bit N-to-1 selector over a flat channel bus.
// Ports: in_data (N_CH*WIDTH), sel (SEL_W) -> dout (WIDTH); 0 if sel out of range.
module mux_n_to_1 #(
  parameter int N_CH  = 16,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) dout = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-to-1 mux with manual and scan modes, valid/ready output stream.
// Ports: clk, rst (async high), in_data, mode, sel_in, start, out_* stream,
// busy, done, err; ch_mask only when MUXSCAN_MASK_EN is defined.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  start,
`ifdef MUXSCAN_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] mux_sel;
  logic [WIDTH-1:0] mux_dout;
  logic             sel_ok;
  logic             first_ok;
  logic [SEL_W-1:0] first_ch;
  logic             is_last;
  logic [SEL_W-1:0] next_ch;

  mux_n_to_1 #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data (in_data),
    .sel     (mux_sel),
    .dout    (mux_dout)
  );

  assign sel_ok = ({1'b0, sel_in} < (SEL_W+1)'(N_CH));

`ifdef MUXSCAN_MASK_EN
  logic [N_CH-1:0] mask_q, mask_d;
  int              first_i;
  int              next_i;

  always_comb begin
    first_i  = next_en(MAX_CH'(ch_mask), -1, N_CH);
    next_i   = next_en(MAX_CH'(mask_q), int'(ch_q), N_CH);
    first_ok = (first_i >= 0);
    first_ch = first_ok ? SEL_W'(first_i) : '0;
    is_last  = (next_i < 0);
    next_ch  = is_last ? ch_q : SEL_W'(next_i);
  end
`else
  assign first_ok = 1'b1;
  assign first_ch = '0;
  assign is_last  = (ch_q == SEL_W'(N_CH - 1));
  assign next_ch  = ch_q + SEL_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mux_sel = ch_q;
`ifdef MUXSCAN_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mode == MODE_MANUAL) begin
            if (sel_ok) begin
              mux_sel = sel_in;
              data_d  = mux_dout;
              ch_d    = sel_in;
              mode_d  = MODE_MANUAL;
              state_d = SHOW;
            end else begin
              err_d = 1'b1;
            end
          end else begin
`ifdef MUXSCAN_MASK_EN
            mask_d = ch_mask;
`endif
            if (first_ok) begin
              mux_sel = first_ch;
              data_d  = mux_dout;
              ch_d    = first_ch;
              mode_d  = MODE_SCAN;
              state_d = SHOW;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      SHOW: begin
        if (out_ready) begin
          if (mode_q == MODE_MANUAL || is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Next word loads on the handshake edge: no bubble.
            mux_sel = next_ch;
            data_d  = mux_dout;
            ch_d    = next_ch;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      mode_q  <= MODE_MANUAL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MUXSCAN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MUXSCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = (state_q == SHOW);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed self-checking bench for mux_scan_n (N_CH=16 and N_CH=12 builds).
// Mask scenarios run only when MUXSCAN_MASK_EN is defined.
module tb_mux_scan_n;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int N2 = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] in_data;
  logic          mode;
  logic [SW-1:0] sel_in;
  logic          start;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;
`ifdef MUXSCAN_MASK_EN
  logic [N-1:0]  ch_mask;
  logic [N2-1:0] ch_mask2;
`endif

  logic [N2*W-1:0] in_data2;
  logic          mode2;
  logic [SW-1:0] sel_in2;
  logic          start2;
  logic [W-1:0]  out_data2;
  logic [SW-1:0] out_ch2;
  logic          out_valid2;
  logic          out_ready2;
  logic          busy2;
  logic          done2;
  logic          err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .mode      (mode),
    .sel_in    (sel_in),
    .start     (start),
`ifdef MUXSCAN_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  mux_scan_n #(.N_CH(N2), .WIDTH(W)) dut12 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data2),
    .mode      (mode2),
    .sel_in    (sel_in2),
    .start     (start2),
`ifdef MUXSCAN_MASK_EN
    .ch_mask   (ch_mask2),
`endif
    .out_data  (out_data2),
    .out_ch    (out_ch2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .busy      (busy2),
    .done      (done2),
    .err       (err2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  task automatic load_default();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(8'hA0 + k);
    for (int k = 0; k < N2; k++) in_data2[k*W +: W] = W'(8'hA0 + k);
  endtask

  task automatic go_scan();
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    sel_in     = '0;
    start      = 1'b0;
    out_ready  = 1'b1;
    mode2      = 1'b0;
    sel_in2    = '0;
    start2     = 1'b0;
    out_ready2 = 1'b1;
    in_data    = '0;
    in_data2   = '0;
`ifdef MUXSCAN_MASK_EN
    ch_mask    = '1;
    ch_mask2   = '1;
`endif
    load_default();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Manual sel 5
    mode = 1'b0; sel_in = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; sel_in = 4'd9;
    check("man_valid", 32'(out_valid), 32'd1);
    check("man_data", 32'(out_data), 32'hA5);
    check("man_ch", 32'(out_ch), 32'd5);
    check("man_busy", 32'(busy), 32'd1);
    tick();
    check("man_valid_off", 32'(out_valid), 32'd0);
    check("man_done", 32'(done), 32'd1);
    check("man_busy_off", 32'(busy), 32'd0);
    check("man_data_hold", 32'(out_data), 32'hA5);
    tick();
    check("man_done_pulse", 32'(done), 32'd0);

    // Manual with stall, then start in the done-edge cycle
    sel_in = 4'd3; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("stall_man_valid", 32'(out_valid), 32'd1);
    check("stall_man_data", 32'(out_data), 32'hA3);
    out_ready = 1'b1; start = 1'b1; sel_in = 4'd7;
    tick();
    start = 1'b0;
    check("done_start_done", 32'(done), 32'd1);
    check("done_start_ign", 32'(out_valid), 32'd0);
    tick();
    check("done_start_idle", 32'(busy), 32'd0);

    // Full scan, ready high; a start mid-scan must be ignored
    go_scan();
    for (int i = 0; i < N; i++) begin
      check($sformatf("scan_ch%0d", i), 32'(out_ch), 32'(i));
      check($sformatf("scan_d%0d", i), 32'(out_data), 32'(8'hA0 + i));
      check($sformatf("scan_v%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("scan_err%0d", i), 32'(err), 32'd0);
      if (i == 4) begin
        start = 1'b1; mode = 1'b0; sel_in = 4'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("scan_done", 32'(done), 32'd1);
    check("scan_valid_off", 32'(out_valid), 32'd0);
    check("scan_busy_off", 32'(busy), 32'd0);
    check("scan_nowrap", 32'(out_ch), 32'd15);
    tick();
    check("scan_done_pulse", 32'(done), 32'd0);

    // Stall at ch 7
    go_scan();
    for (int i = 0; i < 7; i++) tick();
    check("st_ch7", 32'(out_ch), 32'd7);
    out_ready = 1'b0;
    set_ch(7, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("st_hold_d%0d", i), 32'(out_data), 32'hA7);
      check($sformatf("st_hold_c%0d", i), 32'(out_ch), 32'd7);
    end
    set_ch(8, 8'h55);
    out_ready = 1'b1;
    tick();
    check("st_ch8", 32'(out_ch), 32'd8);
    check("st_d8", 32'(out_data), 32'h55);
    for (int i = 0; i < 7; i++) tick();
    check("st_last", 32'(out_ch), 32'd15);
    tick();
    check("st_done", 32'(done), 32'd1);
    load_default();
    tick();

    // Async reset at ch 9
    go_scan();
    for (int i = 0; i < 9; i++) tick();
    check("ar_ch9", 32'(out_ch), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_ch", 32'(out_ch), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    tick();
    check("ar_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    go_scan();
    check("ar_restart_ch", 32'(out_ch), 32'd0);
    check("ar_restart_d", 32'(out_data), 32'hA0);
    for (int i = 0; i < N; i++) tick();
    check("ar_restart_done", 32'(done), 32'd1);
    tick();

    // N_CH=12: out-of-range and last-channel manual select
    mode2 = 1'b0; sel_in2 = 4'd13; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("n12_err", 32'(err2), 32'd1);
    check("n12_valid", 32'(out_valid2), 32'd0);
    check("n12_busy", 32'(busy2), 32'd0);
    tick();
    check("n12_err_pulse", 32'(err2), 32'd0);
    sel_in2 = 4'd11; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("n12_sel11_d", 32'(out_data2), 32'hAB);
    check("n12_sel11_err", 32'(err2), 32'd0);
    tick();
    // Scan on 12 channels: done after 13 cycles
    mode2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < N2; i++) tick();
    check("n12_scan_done", 32'(done2), 32'd1);
    check("n12_scan_last", 32'(out_ch2), 32'd11);
    tick();

`ifdef MUXSCAN_MASK_EN
    ch_mask = 16'h8421;
    go_scan();
    ch_mask = '1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mk_ch%0d", i), 32'(out_ch), 32'(i * 5));
      check($sformatf("mk_d%0d", i), 32'(out_data), 32'(8'hA0 + i * 5));
      check($sformatf("mk_v%0d", i), 32'(out_valid), 32'd1);
      tick();
    end
    check("mk_done", 32'(done), 32'd1);
    check("mk_idle", 32'(busy), 32'd0);
    tick();
    ch_mask = '0;
    go_scan();
    check("mk0_err", 32'(err), 32'd1);
    check("mk0_valid", 32'(out_valid), 32'd0);
    check("mk0_done", 32'(done), 32'd0);
    tick();
    check("mk0_err_pulse", 32'(err), 32'd0);
    mode = 1'b0; sel_in = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    check("mk_man_ign", 32'(out_data), 32'hA6);
    tick();
    ch_mask = '1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-to-1 channel multiplexer. Replaces fixed 4:1 and 16:1 combinational muxing where a consumer needs a valid/ready stream.
- Two modes: manual, which delivers one selected channel, and scan, which sweeps every channel in order.
- Output is a registered valid/ready stream tagged with the channel index.
- Sits between a bank of parallel data sources and a single serial consumer.

Parameters:
- N_CH, 16: number of input channels, 2 or more; need not be a power of 2.
- WIDTH, 8: bits per channel.
- SEL_W, $clog2(N_CH): width of the channel index; derived, do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*WIDTH  flat channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = scan; sampled only on an accepted start.
- sel_in  input  SEL_W  channel for manual mode; sampled only on an accepted start.
- start  input  1  one-cycle request; honoured only in IDLE.
- out_data  output  WIDTH  registered channel data.
- out_ch  output  SEL_W  index of the channel in out_data.
- out_valid  output  1  out_data/out_ch are valid.
- out_ready  input  1  consumer accepts the current word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word of a transfer is accepted.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: state = IDLE; out_data = 0, out_ch = 0, out_valid = 0, busy = 0, done = 0, err = 0. Reset asserted mid-transfer aborts it immediately, with no done pulse.
- States: IDLE, SHOW.
- IDLE, start = 1, mode = 0:
  - sel_in < N_CH: register in_data[sel_in] and sel_in; enter SHOW.
  - sel_in >= N_CH: err = 1 next cycle; stay in IDLE.
- IDLE, start = 1, mode = 1: register channel 0 (or the first enabled channel, see Optional Feature); enter SHOW.
- Start latency: out_valid rises exactly 1 cycle after the accepted start.
- SHOW holds out_valid = 1. out_data and out_ch stay stable while out_ready = 0. in_data changes do not affect a held word.
- Handshake = out_valid & out_ready, sampled at a rising edge.
  - Manual: go to IDLE; out_valid = 0 and done = 1 in the next cycle.
  - Scan, not the last channel: next cycle out_ch = next channel and out_data = in_data of that channel sampled at the handshake edge. out_valid stays 1, giving zero-bubble back-to-back transfer.
  - Scan, last channel (N_CH-1 or the last enabled channel): go to IDLE; done pulses; out_ch is not wrapped.
- start while busy: ignored; no err; the transfer continues unaffected.
- start in the same cycle as done: ignored (the FSM is still in SHOW on that edge).
- A scan with out_ready held at 1 takes N_CH+1 cycles from start to done.
- Mode or sel_in changes during SHOW have no effect.
- out_data holds its last value in IDLE.

Optional Feature:
- Macro: MUXSCAN_MASK_EN.
- Defined:
  - Adds input ch_mask [N_CH], sampled on an accepted scan start; bit k = 1 means channel k is enabled.
  - Scan visits only enabled channels, in ascending order, with no bubble cycles for skipped channels.
  - All-zero mask: err pulses 1 cycle after start; FSM stays in IDLE; no done.
  - Manual mode ignores the mask.
- Undefined: the port is absent and every channel is enabled.

Decomposition:
- Package mux_scan_pkg:
  - state enum (IDLE, SHOW);
  - mode constants MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
- Sub-module mux_n_to_1: combinational parametrised WIDTH-bit N-to-1 selector (in_data, sel -> dout). It is used for the load path.
- With MUXSCAN_MASK_EN, the next-enabled-channel search is a function in the package: a priority search above the current index.

Test Plan (N_CH=16, WIDTH=8, channel k data = 8'hA0+k):
- Manual, sel_in=5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=5; following cycle out_valid=0, done=1.
- Scan with out_ready=1 throughout -> out_ch 0..15 on 16 consecutive cycles with data A0..AF; done in cycle 17; busy low afterwards.
- Scan with out_ready low for 3 cycles at ch 7; change channel 7 input to 8'h00 during the stall -> out_data holds 8'hA7; on resume, ch 8 shows the current channel 8 input.
- N_CH=12 build, manual sel_in=13 -> err pulse, out_valid stays 0; start during an active scan -> ignored, sequence intact.
- Reset asserted at ch 9 of a scan -> all outputs 0 asynchronously; after release a new start runs from ch 0.
- MUXSCAN_MASK_EN, ch_mask=16'h8421 -> out_ch 0,5,10,15 back-to-back, then done; ch_mask=0 -> err only.
